// File: rtl/boot_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : boot_loader_pkg
// Description : Shared CPU constants: boot-loader default geometry and
//               FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package boot_loader_pkg;

    // Default BIOS image geometry
    localparam int C_BIOS_SIZE = 18;
    localparam int C_ADDR_W    = 26;
    localparam int C_DATA_W    = 32;

    // Boot-loader state encoding (explicit 2-bit width)
    localparam logic [1:0] C_ST_IDLE   = 2'd0;
    localparam logic [1:0] C_ST_READ   = 2'd1;
    localparam logic [1:0] C_ST_WRITE  = 2'd2;
    localparam logic [1:0] C_ST_FINISH = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = C_ST_IDLE,
        ST_READ   = C_ST_READ,
        ST_WRITE  = C_ST_WRITE,
        ST_FINISH = C_ST_FINISH
    } boot_state_t;

    // Bits needed to hold an index in 0..n-1 (at least one bit)
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : boot_loader_pkg
`default_nettype wire

// File: rtl/boot_loader.sv
`default_nettype none
// ============================================================================
// Module      : boot_loader
// Description : Copies BIOS_SIZE words from a combinational BIOS ROM into
//               instruction memory, one READ + WRITE pair per word, holding
//               the CPU until the copy completes. Tracks the XOR checksum of
//               every word written.
// Revision    : 1.0 - initial release
// ============================================================================
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int BIOS_SIZE = C_BIOS_SIZE,
    parameter int ADDR_W    = C_ADDR_W,
    parameter int DATA_W    = C_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic              mem_ready,
    output logic              busy,
    output logic              done,
    output logic              cpu_hold,
    output logic [DATA_W-1:0] checksum
);

    localparam int                 c_IDX_W = idx_width(BIOS_SIZE);
    localparam logic [c_IDX_W-1:0] c_LAST  = c_IDX_W'(BIOS_SIZE - 1);

    boot_state_t         r_state;
    boot_state_t         w_state_nxt;
    logic [c_IDX_W-1:0]  r_index;
    logic [DATA_W-1:0]   r_data;
    logic [DATA_W-1:0]   r_checksum;
    logic                w_start_copy;
    logic                w_accept;

    // State register; reset forces IDLE immediately
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; start is only honoured when no copy is running
    always_comb begin
        w_state_nxt  = r_state;
        w_start_copy = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE, ST_FINISH: begin
                if (start) begin
                    w_start_copy = 1'b1;
                    w_state_nxt  = ST_READ;
                end
            end
            ST_READ: begin
                w_state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                if (mem_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (r_index == c_LAST) ? ST_FINISH : ST_READ;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath: index, captured ROM word and running checksum
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_index    <= '0;
            r_data     <= '0;
            r_checksum <= '0;
        end else begin
            if (w_start_copy) begin
                r_index    <= '0;
                r_checksum <= '0;
            end
            if (r_state == ST_READ) begin
                r_data <= rom_data;
            end
            if (w_accept) begin
                r_checksum <= r_checksum ^ r_data;
                // The last index is held so no write past the image occurs
                if (r_index != c_LAST) begin
                    r_index <= r_index + 1'b1;
                end
            end
        end
    end

    assign rom_addr    = ADDR_W'(r_index);
    assign mem_wr_addr = ADDR_W'(r_index);
    assign mem_wr_data = r_data;
    assign mem_wr_en   = (r_state == ST_WRITE);
    assign busy        = (r_state == ST_READ) || (r_state == ST_WRITE);
    assign done        = (r_state == ST_FINISH);
    assign cpu_hold    = (r_state != ST_FINISH);
    assign checksum    = r_checksum;

endmodule : boot_loader
`default_nettype wire

// File: tb/tb_boot_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_boot_loader
// Description : Self-checking bench for boot_loader: cycle model of the copy
//               protocol compared every cycle, plus directed scenarios with
//               literal expectations; a second BIOS_SIZE=1 instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_boot_loader;

    localparam int N  = 18;
    localparam int AW = 26;
    localparam int DW = 32;

    // XOR of the standard image: 0x58000001 ^ 0x60000000 ^ (XOR of i*0x01010101, i=1..16)
    localparam logic [31:0] c_IMG_XOR = 32'h2810_1011;

    logic          clock;
    logic          reset;
    logic          start;
    logic          mem_ready;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic          mem_wr_en;
    logic [AW-1:0] mem_wr_addr;
    logic [DW-1:0] mem_wr_data;
    logic          busy;
    logic          done;
    logic          cpu_hold;
    logic [DW-1:0] checksum;

    logic          start1;
    logic [AW-1:0] rom_addr1;
    logic [DW-1:0] rom_data1;
    logic          mem_wr_en1;
    logic [AW-1:0] mem_wr_addr1;
    logic [DW-1:0] mem_wr_data1;
    logic          busy1;
    logic          done1;
    logic          cpu_hold1;
    logic [DW-1:0] checksum1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t0       = 0;
    bit cmp_en   = 0;

    // Standard BIOS ROM image
    function automatic logic [31:0] rom_word(input logic [AW-1:0] a);
        if (a == 0)       return 32'h5800_0001;
        else if (a == 17) return 32'h6000_0000;
        else if (a < 17)  return 32'h0101_0101 * 32'(a);
        else              return 32'hDEAD_BEEF;
    endfunction

    assign rom_data  = rom_word(rom_addr);
    assign rom_data1 = rom_word(rom_addr1);

    boot_loader dut (
        .clock(clock), .reset(reset), .start(start),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_ready(mem_ready), .busy(busy), .done(done), .cpu_hold(cpu_hold),
        .checksum(checksum)
    );

    boot_loader #(.BIOS_SIZE(1)) dut1 (
        .clock(clock), .reset(reset), .start(start1),
        .rom_addr(rom_addr1), .rom_data(rom_data1),
        .mem_wr_en(mem_wr_en1), .mem_wr_addr(mem_wr_addr1), .mem_wr_data(mem_wr_data1),
        .mem_ready(1'b1), .busy(busy1), .done(done1), .cpu_hold(cpu_hold1),
        .checksum(checksum1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Protocol model: a copy is a sequence of words, each one read cycle and
    // one or more write cycles ending when memory is ready.
    bit          m_run  = 0;
    bit          m_wr   = 0;
    bit          m_done = 0;
    int          m_word = 0;
    logic [31:0] m_chk  = '0;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_run <= 0; m_wr <= 0; m_done <= 0; m_word <= 0; m_chk <= '0;
        end else if (!m_run) begin
            if (start) begin
                m_run <= 1; m_wr <= 0; m_done <= 0; m_word <= 0; m_chk <= '0;
            end
        end else if (!m_wr) begin
            m_wr <= 1;
        end else if (mem_ready) begin
            m_chk <= m_chk ^ rom_word(AW'(m_word));
            m_wr  <= 0;
            if (m_word == N - 1) begin
                m_run  <= 0;
                m_done <= 1;
            end else begin
                m_word <= m_word + 1;
            end
        end
    end

    // Per-cycle comparison against the model, plus a log of accepted writes
    logic [AW-1:0] wlog[$];
    logic [DW-1:0] wdat[$];
    int            w1_cnt  = 0;
    logic [AW-1:0] w1_addr = '0;

    always @(negedge clock) begin
        if (cmp_en) begin
            check("busy",        busy,        m_run);
            check("done",        done,        m_done);
            check("cpu_hold",    cpu_hold,    !m_done);
            check("mem_wr_en",   mem_wr_en,   m_run && m_wr);
            check("rom_addr",    rom_addr,    m_word);
            check("mem_wr_addr", mem_wr_addr, m_word);
            check("checksum",    checksum,    m_chk);
            if (m_run && m_wr)
                check("mem_wr_data", mem_wr_data, rom_word(AW'(m_word)));
            if (mem_wr_en && mem_ready) begin
                wlog.push_back(mem_wr_addr);
                wdat.push_back(mem_wr_data);
            end
            if (mem_wr_en1) begin
                w1_cnt++;
                w1_addr = mem_wr_addr1;
            end
        end
    end

    task automatic start_copy();
        @(posedge clock); #1;
        start = 1'b1;
        t0 = cyc + 1;
        wlog.delete();
        wdat.delete();
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int el, output bit hold_before);
        el = -1;
        hold_before = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clock);
            if (done) begin
                el = cyc - t0;
                break;
            end
            hold_before = cpu_hold;
        end
        if (el < 0) check("done_timeout", 0, 1);
    endtask

    task automatic wait_for(input int addr, input bit in_write, output bit ok);
        ok = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clock);
            if (busy && (mem_wr_en == in_write) && (rom_addr == AW'(addr))) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("wait_timeout", addr, 0);
    endtask

    initial begin
        int          el;
        bit          hb;
        bit          ok;
        int          cnt3;
        logic [31:0] x;
        logic [31:0] chk1;

        reset = 1'b0; start = 1'b0; start1 = 1'b0; mem_ready = 1'b1;
        #1 reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        cmp_en = 1;

        // Reset state
        @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hold", cpu_hold, 1);
        check("rst_wr_en", mem_wr_en, 0);
        check("rst_chk", checksum, 0);

        // Full copy with memory always ready
        start_copy();
        wait_done(el, hb);
        check("s1_time", el, 36);
        check("s1_hold_fall", {hb, cpu_hold}, 2'b10);
        check("s1_nwrites", wlog.size(), N);
        for (int i = 0; i < wlog.size(); i++) check("s1_order", wlog[i], i);
        check("s1_word0", wdat[0], 32'h5800_0001);
        check("s1_word17", wdat[N-1], 32'h6000_0000);
        x = '0;
        for (int i = 0; i < N; i++) x ^= rom_word(AW'(i));
        check("s1_chk_sum", checksum, x);
        check("s1_chk_lit", checksum, c_IMG_XOR);
        chk1 = checksum;

        // Restart from FINISH with a 5-cycle memory stall on word 3
        start_copy();
        @(negedge clock);
        check("s2_done_drop", done, 0);
        wait_for(3, 0, ok);
        @(posedge clock); #1 mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("s2_stall_en", mem_wr_en, 1);
            check("s2_stall_addr", mem_wr_addr, 3);
            check("s2_stall_data", mem_wr_data, rom_word(AW'(3)));
            @(posedge clock);
        end
        #1 mem_ready = 1'b1;
        wait_done(el, hb);
        check("s2_time", el, 41);
        cnt3 = 0;
        foreach (wlog[i]) if (wlog[i] == 3) cnt3++;
        check("s2_addr3_once", cnt3, 1);
        check("s2_nwrites", wlog.size(), N);
        check("s2_chk_same", checksum, chk1);

        // Start pulsed mid-copy is ignored
        start_copy();
        wait_for(7, 0, ok);
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        wait_done(el, hb);
        check("s3_time", el, 36);
        check("s3_nwrites", wlog.size(), N);
        check("s3_chk", checksum, c_IMG_XOR);

        // Reset in the middle of writing word 9
        start_copy();
        wait_for(9, 1, ok);
        #1 reset = 1'b1;
        #1;
        check("s4_busy", busy, 0);
        check("s4_done", done, 0);
        check("s4_hold", cpu_hold, 1);
        check("s4_wr_en", mem_wr_en, 0);
        check("s4_wr_addr", mem_wr_addr, 0);
        check("s4_wr_data", mem_wr_data, 0);
        check("s4_rom_addr", rom_addr, 0);
        check("s4_chk", checksum, 0);
        @(posedge clock); #1 reset = 1'b0;
        start_copy();
        wait_done(el, hb);
        check("s4_time", el, 36);
        check("s4_nwrites", wlog.size(), N);
        if (wlog.size() > 0) check("s4_first_addr", wlog[0], 0);
        check("s4_chk_after", checksum, c_IMG_XOR);

        // Single-word image
        check("s6_idle", {done1, busy1, cpu_hold1}, 3'b001);
        @(posedge clock); #1 start1 = 1'b1;
        t0 = cyc + 1;
        @(posedge clock); #1 start1 = 1'b0;
        el = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (done1) begin
                el = cyc - t0;
                break;
            end
        end
        check("s6_time", el, 2);
        check("s6_nwrites", w1_cnt, 1);
        check("s6_addr", w1_addr, 0);
        check("s6_chk", checksum1, 32'h5800_0001);
        check("s6_hold", cpu_hold1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_boot_loader
`default_nettype wire

// File: doc/boot_loader.md
BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 Parameter BIOS_SIZE, default 18: number of 32-bit words copied from BIOS ROM.
REQ-002 Parameter ADDR_W, default 26: width of ROM and instruction-memory word addresses.
REQ-003 Parameter DATA_W, default 32: instruction word width.
REQ-004 clock  input  1  single system clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to begin a copy.
REQ-007 rom_addr  output  ADDR_W  word address driven to BIOS ROM (combinational ROM, same-cycle data).
REQ-008 rom_data  input  DATA_W  instruction word returned by ROM.
REQ-009 mem_wr_en  output  1  write request to instruction memory.
REQ-010 mem_wr_addr  output  ADDR_W  instruction-memory write word address.
REQ-011 mem_wr_data  output  DATA_W  instruction-memory write data.
REQ-012 mem_ready  input  1  memory accepts the write in any cycle where mem_wr_en and mem_ready are both 1.
REQ-013 busy  output  1  copy in progress.
REQ-014 done  output  1  copy complete; held until the next start or reset.
REQ-015 cpu_hold  output  1  holds the CPU PC at 0 while 1.
REQ-016 checksum  output  DATA_W  XOR of all words written in the last copy.

Function
REQ-017 The FSM SHALL have the states IDLE, READ, WRITE and FINISH.
- IDLE, start=1 -> READ; index<=0; checksum<=0.
REQ-018 READ SHALL last one cycle: rom_addr=index, register rom_data into the data register, then go to WRITE.
REQ-019 WRITE SHALL hold mem_wr_en=1, mem_wr_addr=index and mem_wr_data=the data register stable until mem_ready=1.
REQ-020 On the accepting edge in WRITE, checksum SHALL be XORed with mem_wr_data.
- If index==BIOS_SIZE-1 -> FINISH.
- Otherwise index+1 -> READ.
REQ-021 Each word SHALL take at least 2 cycles; with mem_ready tied to 1, a full copy takes exactly 2*BIOS_SIZE cycles from the start edge to the done edge.
REQ-022 FINISH SHALL drive done=1, busy=0 and cpu_hold=0.
- It stays in FINISH until start=1, which restarts the copy at index 0 and clears checksum and done.
REQ-023 busy SHALL be 1 exactly while in READ or WRITE.
REQ-024 cpu_hold SHALL be 1 in IDLE, READ and WRITE.
REQ-025 start SHALL be ignored while busy=1.
REQ-026 mem_wr_en SHALL be 0 outside WRITE.
- rom_addr SHALL equal index in all states.
REQ-027 Index SHALL never exceed BIOS_SIZE-1; no wrap-around write to address BIOS_SIZE shall occur.
REQ-028 Index and addresses SHALL be zero-extended to ADDR_W.
REQ-029 If mem_ready is 0 indefinitely, the block SHALL stall in WRITE with all outputs stable.
- No timeout.

Reset
REQ-030 Asserting reset at any time, including mid-copy, SHALL immediately force IDLE and set outputs to:
- index=0, mem_wr_en=0, mem_wr_addr=0, mem_wr_data=0, rom_addr=0
- busy=0, done=0, cpu_hold=1, checksum=0
REQ-031 A write in progress when reset asserts SHALL be abandoned; the memory contents written so far are not guaranteed.

Structure
REQ-032 The state encoding constants and the default BIOS_SIZE/ADDR_W/DATA_W values SHALL reside in the shared CPU constants package.
REQ-033 boot_loader SHALL be a single module with no sub-modules; the ROM is instantiated outside it.

Verification
REQ-034 The bench SHALL cover the following directed scenarios.
- Reset, then a start pulse with mem_ready=1 and the standard 18-word BIOS ROM:
  - addresses 0..17 are written in order; word 0 = 0x58000001, word 17 = 0x60000000;
  - done rises 36 cycles after start;
  - cpu_hold falls in the same cycle as done;
  - checksum equals the XOR of all 18 words.
- mem_ready low for 5 cycles during word 3:
  - mem_wr_addr=3 and mem_wr_data stay stable;
  - exactly one write to address 3;
  - total copy time is 41 cycles.
- start pulsed again at word 7 while busy:
  - ignored; the copy completes normally with 18 writes.
- reset asserted at word 9 (during WRITE):
  - all outputs return to reset values asynchronously, before the next clock edge;
  - cpu_hold=1;
  - a following start recopies from address 0.
- start issued in FINISH:
  - done drops the next cycle;
  - a second full copy of 18 writes runs;
  - checksum recomputes to the same value as the first copy.
- BIOS_SIZE=1 build:
  - one write to address 0;
  - done asserted 2 cycles after start.
